// File: rtl/tnn_neuron_scheduler_pkg.sv
// Shared types and constants for the TNN neuron scheduler: operand widths,
// FSM state encoding, routing-table row layout and the feature-select helper.
package tnn_sched_pkg;

    localparam int FEAT_W = 3;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Operand a sits at the LSBs so a cfg_data word maps straight onto a row.
    typedef struct packed {
        logic [IDX_W-1:0] e;
        logic [IDX_W-1:0] d;
        logic [IDX_W-1:0] c;
        logic [IDX_W-1:0] b;
        logic [IDX_W-1:0] a;
    } route_t;

    typedef struct packed {
        logic [FEAT_W-1:0] e;
        logic [FEAT_W-1:0] d;
        logic [FEAT_W-1:0] c;
        logic [FEAT_W-1:0] b;
        logic [FEAT_W-1:0] a;
    } operands_t;

    localparam route_t DEFAULT_ROUTE = '{e: 4'd4, d: 4'd3, c: 4'd2, b: 4'd1, a: 4'd0};

    // Select one feature from a vector padded to 2**IDX_W entries; indices
    // beyond the real feature count read as zero.
    function automatic logic [FEAT_W-1:0] pick_feat(
        input logic [(2**IDX_W)*FEAT_W-1:0] feats,
        input logic [IDX_W-1:0]             idx,
        input int                           num_feat
    );
        logic [FEAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < 2**IDX_W; i++) begin
            if (idx == IDX_W'(i) && i < num_feat) r = feats[i*FEAT_W +: FEAT_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/tnn_neuron_scheduler_if.sv
// Sample-in / result-out handshake bundle between the scheduler and its
// producer and downstream voter.
interface tnn_sched_if #(
    parameter int NUM_FEAT    = 11,
    parameter int NUM_NEURONS = 7
) ();
    logic                                      in_valid;
    logic                                      in_ready;
    logic [NUM_FEAT*tnn_sched_pkg::FEAT_W-1:0] in_feat;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [NUM_NEURONS-1:0]                    out_bits;
    logic [tnn_sched_pkg::CNT_W-1:0]           out_count;

    // Scheduler side.
    modport slave (
        input  in_valid, in_feat, out_ready,
        output in_ready, out_valid, out_bits, out_count
    );

    // Producer / voter side.
    modport master (
        output in_valid, in_feat, out_ready,
        input  in_ready, out_valid, out_bits, out_count
    );
endinterface

// File: rtl/tnn_neuron_scheduler_route_table.sv
// Per-neuron routing table: one route_t row per logical neuron, synchronous
// write, combinational read, every row reset to the default route.
module tnn_route_table
    import tnn_sched_pkg::*;
#(
    parameter int NUM_NEURONS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  route_t     wdata,
    input  logic [3:0] raddr,
    output route_t     rdata
);

    route_t rows_q [NUM_NEURONS];

    // Row storage; a reset restores the default routing of every neuron.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this register file is reset explicitly because a reset mid-run must return the table to the default routing.
            for (int i = 0; i < NUM_NEURONS; i++) rows_q[i] <= DEFAULT_ROUTE;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (we && waddr == 4'(i)) rows_q[i] <= wdata;
            end
        end
    end

    // Read port on the current neuron index; out-of-range reads give the default.
    always_comb begin
        rdata = DEFAULT_ROUTE;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (raddr == 4'(i)) rdata = rows_q[i];
        end
    end

endmodule

// File: rtl/tnn_neuron_scheduler.sv
// Time-multiplexes one shared combinational TNN neuron core over NUM_NEURONS
// logical neurons: latches a sample, issues routed operands one neuron per
// cycle, captures each decision one cycle later and returns bits + count.
module tnn_neuron_scheduler
    import tnn_sched_pkg::*;
#(
    parameter int NUM_FEAT    = 11,
    parameter int NUM_NEURONS = 7
) (
    input  logic               clk,
    input  logic               rst,
    tnn_sched_if.slave         bus,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_addr,
    input  logic [5*IDX_W-1:0] cfg_data,
    output logic               cfg_err,
    output logic [FEAT_W-1:0]  core_a,
    output logic [FEAT_W-1:0]  core_b,
    output logic [FEAT_W-1:0]  core_c,
    output logic [FEAT_W-1:0]  core_d,
    output logic [FEAT_W-1:0]  core_e,
    input  logic               core_out
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_LAST  = LAST;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]                 state_q, state_d;
    logic [3:0]                 k_q, k_d;
    logic [NUM_FEAT*FEAT_W-1:0] feat_q, feat_d;
    logic [NUM_NEURONS-1:0]     bits_q, bits_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       out_valid_q, out_valid_d;
    logic                       cfg_err_q, cfg_err_d;
    operands_t                  opnd_q, opnd_d;

    logic                       cfg_ok;
    logic [3:0]                 cap_idx;
    route_t                     route;
    logic [(2**IDX_W)*FEAT_W-1:0] feats_ext;

    assign feats_ext = {{((2**IDX_W) - NUM_FEAT)*FEAT_W{1'b0}}, feat_q};
    assign cap_idx   = k_q - 4'd1;

    // A write lands only while idle with no competing sample and a valid row.
    assign cfg_ok = cfg_we && (state_q == ST_IDLE) && !bus.in_valid
                    && (int'(cfg_addr) < NUM_NEURONS);

    tnn_route_table #(.NUM_NEURONS(NUM_NEURONS)) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_ok),
        .waddr (cfg_addr),
        .wdata (route_t'(cfg_data)),
        .raddr (k_q),
        .rdata (route)
    );

    // Next-state logic for the FSM, sample register, operands and accumulators.
    always_comb begin
        // NOTE: every target gets a hold default first so no path through the case infers a latch.
        state_d     = state_q;
        k_d         = k_q;
        feat_d      = feat_q;
        bits_d      = bits_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        opnd_d      = opnd_q;
        cfg_err_d   = cfg_we && !cfg_ok;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    feat_d  = bus.in_feat;
                    bits_d  = '0;
                    count_d = '0;
                    k_d     = 4'd0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                opnd_d.a = pick_feat(feats_ext, route.a, NUM_FEAT);
                opnd_d.b = pick_feat(feats_ext, route.b, NUM_FEAT);
                opnd_d.c = pick_feat(feats_ext, route.c, NUM_FEAT);
                opnd_d.d = pick_feat(feats_ext, route.d, NUM_FEAT);
                opnd_d.e = pick_feat(feats_ext, route.e, NUM_FEAT);
                // The core output now reflects the neuron issued last cycle.
                if (k_q != 4'd0) begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        if (cap_idx == 4'(i)) bits_d[i] = core_out;
                    end
                    count_d = count_q + {{(CNT_W-1){1'b0}}, core_out};
                end
                k_d = k_q + 4'd1;
                if (k_q == 4'(NUM_NEURONS - 1)) state_d = ST_LAST;
            end
            ST_LAST: begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    if (cap_idx == 4'(i)) bits_d[i] = core_out;
                end
                count_d     = count_q + {{(CNT_W-1){1'b0}}, core_out};
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            default: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    // State registers; synchronous reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            feat_q      <= '0;
            bits_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            opnd_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            feat_q      <= feat_d;
            bits_q      <= bits_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
            opnd_q      <= opnd_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = bits_q;
    assign bus.out_count = count_q;
    assign cfg_err       = cfg_err_q;
    assign core_a        = opnd_q.a;
    assign core_b        = opnd_q.b;
    assign core_c        = opnd_q.c;
    assign core_d        = opnd_q.d;
    assign core_e        = opnd_q.e;

endmodule
